// File: rtl/frv_mmio_arb_if.sv
// ----------------------------------------------------------------------------
// frv_mmio_arb_if
// Bundle of every bus signal around the two-port timer/counter MMIO arbiter.
//
// Handshake: a requester raises pX_req with a stable payload (wen, lock, addr,
// wdata) and holds it until pX_gnt is 1 in the same cycle, which is the
// transfer cycle. The target sees t_en with the payload in that cycle and
// returns t_rdata/t_error exactly one cycle later. The owning port sees that
// response as pX_rsp/pX_rdata/pX_error in that same later cycle. The target
// has no backpressure.
//
// Modports:
//   slave  - the arbiter: takes requests and target response, drives grants,
//            responses, target request and debug state.
//   master - the environment: the two requesters plus the target.
//
// dbg_* expose the arbiter's registered state (priority pointer, lock,
// owner and outstanding flag) so checkers can observe it directly.
// ----------------------------------------------------------------------------
interface frv_mmio_arb_if;
    logic        p0_req;
    logic        p0_wen;
    logic        p0_lock;
    logic [31:0] p0_addr;
    logic [31:0] p0_wdata;
    logic        p0_gnt;
    logic        p0_rsp;
    logic [31:0] p0_rdata;
    logic        p0_error;

    logic        p1_req;
    logic        p1_wen;
    logic        p1_lock;
    logic [31:0] p1_addr;
    logic [31:0] p1_wdata;
    logic        p1_gnt;
    logic        p1_rsp;
    logic [31:0] p1_rdata;
    logic        p1_error;

    logic        t_en;
    logic        t_wen;
    logic [31:0] t_addr;
    logic [31:0] t_wdata;
    logic [31:0] t_rdata;
    logic        t_error;

    logic        dbg_prio;
    logic        dbg_lock_held;
    logic        dbg_lock_owner;
    logic        dbg_owner;
    logic        dbg_outstanding;

    modport slave (
        input  p0_req, p0_wen, p0_lock, p0_addr, p0_wdata,
        output p0_gnt, p0_rsp, p0_rdata, p0_error,
        input  p1_req, p1_wen, p1_lock, p1_addr, p1_wdata,
        output p1_gnt, p1_rsp, p1_rdata, p1_error,
        output t_en, t_wen, t_addr, t_wdata,
        input  t_rdata, t_error,
        output dbg_prio, dbg_lock_held, dbg_lock_owner, dbg_owner, dbg_outstanding
    );

    modport master (
        output p0_req, p0_wen, p0_lock, p0_addr, p0_wdata,
        input  p0_gnt, p0_rsp, p0_rdata, p0_error,
        output p1_req, p1_wen, p1_lock, p1_addr, p1_wdata,
        input  p1_gnt, p1_rsp, p1_rdata, p1_error,
        input  t_en, t_wen, t_addr, t_wdata,
        output t_rdata, t_error,
        input  dbg_prio, dbg_lock_held, dbg_lock_owner, dbg_owner, dbg_outstanding
    );
endinterface

// File: rtl/frv_mmio_arb.sv
// ----------------------------------------------------------------------------
// frv_mmio_arb
// Two-port round-robin arbiter in front of a single-outstanding, fixed
// one-cycle-latency timer/counter MMIO target. A port may lock the target
// across consecutive accesses (e.g. atomic hi/lo access to mtime/mtimecmp).
//
// Ports:
//   g_clk   - clock, all state changes on its rising edge
//   g_reset - synchronous active-high reset
//   bus     - frv_mmio_arb_if.slave: requester ports p0/p1, target port t_*,
//             debug state dbg_*
// Parameter:
//   PRIO_RESET - port holding round-robin priority after reset
// ----------------------------------------------------------------------------
module frv_mmio_arb #(
    parameter logic PRIO_RESET = 1'b0
) (
    input logic            g_clk,
    input logic            g_reset,
    frv_mmio_arb_if.slave  bus
);

    logic outstanding;
    logic owner;
    logic lock_held;
    logic lock_owner;
    logic prio;

    logic win_vld;
    logic win;
    logic win_lock;
    logic rsp_vld;

    // Winner selection. A held lock excludes the other port entirely; it
    // persists for as long as the holder stays idle.
    always_comb begin
        win_vld = 1'b0;
        win     = 1'b0;
        if (!g_reset) begin
            if (lock_held) begin
                win     = lock_owner;
                win_vld = lock_owner ? bus.p1_req : bus.p0_req;
            end else if (bus.p0_req && bus.p1_req) begin
                win_vld = 1'b1;
                win     = prio;
            end else if (bus.p0_req) begin
                win_vld = 1'b1;
            end else if (bus.p1_req) begin
                win_vld = 1'b1;
                win     = 1'b1;
            end
        end
    end

    assign win_lock = win ? bus.p1_lock : bus.p0_lock;

    assign bus.p0_gnt  = win_vld & ~win;
    assign bus.p1_gnt  = win_vld &  win;

    assign bus.t_en    = win_vld;
    assign bus.t_wen   = win_vld & (win ? bus.p1_wen : bus.p0_wen);
    assign bus.t_addr  = win_vld ? (win ? bus.p1_addr  : bus.p0_addr)  : 32'd0;
    assign bus.t_wdata = win_vld ? (win ? bus.p1_wdata : bus.p0_wdata) : 32'd0;

    // Responses are suppressed during reset so a pending access is dropped.
    assign rsp_vld      = outstanding & ~g_reset;
    assign bus.p0_rsp   = rsp_vld & ~owner;
    assign bus.p1_rsp   = rsp_vld &  owner;
    assign bus.p0_rdata = bus.p0_rsp ? bus.t_rdata : 32'd0;
    assign bus.p1_rdata = bus.p1_rsp ? bus.t_rdata : 32'd0;
    assign bus.p0_error = bus.p0_rsp & bus.t_error;
    assign bus.p1_error = bus.p1_rsp & bus.t_error;

    always_ff @(posedge g_clk) begin
        if (g_reset) begin
            outstanding <= 1'b0;
            owner       <= 1'b0;
            lock_held   <= 1'b0;
            lock_owner  <= 1'b0;
            prio        <= PRIO_RESET;
        end else begin
            outstanding <= win_vld;
            if (win_vld) begin
                owner <= win;
                if (win_lock) begin
                    // Locked access: keep the target, leave priority alone.
                    lock_held  <= 1'b1;
                    lock_owner <= win;
                end else begin
                    // An unlocked grant only reaches a locked arbiter via the
                    // holder, so clearing here is the release.
                    lock_held <= 1'b0;
                    prio      <= ~win;
                end
            end
        end
    end

    assign bus.dbg_prio        = prio;
    assign bus.dbg_lock_held   = lock_held;
    assign bus.dbg_lock_owner  = lock_owner;
    assign bus.dbg_owner       = owner;
    assign bus.dbg_outstanding = outstanding;

endmodule

// File: doc/frv_mmio_arb.md
FRV_MMIO_ARB -- requirements
Module: frv_mmio_arb

Interface
REQ-001 SHALL have parameter PRIO_RESET, default 1'b0, meaning the port holding round-robin priority after reset (0 = p0, 1 = p1).
REQ-002 SHALL have ports g_clk input 1, the single clock; all state changes on its rising edge.
REQ-003 SHALL have g_reset input 1, a synchronous active-high reset.
REQ-004 SHALL have, for each requester X in {0,1}: pX_req input 1, request valid.
REQ-005 SHALL have pX_wen input 1, write (1) or read (0).
REQ-006 SHALL have pX_lock input 1, keep ownership after this access.
REQ-007 SHALL have pX_addr input 32, access address.
REQ-008 SHALL have pX_wdata input 32, write data.
REQ-009 SHALL have pX_gnt output 1, request accepted this cycle.
REQ-010 SHALL have pX_rsp output 1, response valid.
REQ-011 SHALL have pX_rdata output 32, read data.
REQ-012 SHALL have pX_error output 1, response error.
REQ-013 SHALL have target ports t_en output 1, t_wen output 1, t_addr output 32 and t_wdata output 32, the timer/counter MMIO request.
REQ-014 SHALL have t_rdata input 32 and t_error input 1, the target response, valid the cycle after t_en.

Function
REQ-015 Winner SHALL be chosen combinationally each cycle from pX_req, the priority pointer (prio) and the lock state.
REQ-016 With no lock held and one requester active, that requester SHALL win.
REQ-017 With no lock held and both requesters active, port prio SHALL win.
REQ-018 With a lock held by port L, only L SHALL be grantable; the other port's requests SHALL wait, with no gnt.
REQ-019 In the grant cycle the winner's pX_gnt SHALL be 1, t_en SHALL be 1, and t_wen/t_addr/t_wdata SHALL equal the winner's inputs; at most one pX_gnt SHALL be 1 per cycle.
REQ-020 With no winner, t_en SHALL be 0 and t_wen/t_addr/t_wdata SHALL be 0.
REQ-021 A requester SHALL hold pX_req and its payload stable until pX_gnt; the arbiter SHALL never grant a deasserted request.
REQ-022 On a grant, registered owner SHALL be set to the winner and outstanding SHALL be set to 1; with no grant, outstanding SHALL be set to 0.
REQ-023 When outstanding = 1, the owner port's pX_rsp SHALL be 1, with pX_rdata = t_rdata and pX_error = t_error; the non-owner's rsp, rdata and error SHALL be 0.
REQ-024 Response latency SHALL be exactly 1 cycle after gnt.
REQ-025 A new grant SHALL be allowed in the same cycle as a response, giving back-to-back throughput of 1 access per cycle.
REQ-026 On a grant to port W with pX_lock = 0, prio SHALL become ~W.
REQ-027 On a grant to port W with pX_lock = 1, prio SHALL be unchanged.
REQ-028 On a grant with pX_lock = 1, lock SHALL be set, held by W.
REQ-029 On a grant to the lock holder with pX_lock = 0, the lock SHALL be released after that access; this allows atomic 64-bit hi/lo sequences on mtime/mtimecmp.
REQ-030 A lock SHALL persist indefinitely while its holder idles; the arbiter SHALL have no timeout.
REQ-031 The target is a single-outstanding, fixed-latency device, so the arbiter SHALL have no backpressure from it.
REQ-032 prio SHALL be a 1-bit pointer that wraps 1->0 and 0->1.

Reset
REQ-033 While g_reset = 1 at a clock edge: outstanding SHALL be 0, owner SHALL be 0, lock SHALL be cleared, and prio SHALL be PRIO_RESET.
REQ-034 While g_reset = 1, all pX_gnt, pX_rsp, pX_rdata, pX_error, t_en, t_wen, t_addr and t_wdata SHALL be 0, including the reset cycle itself.
REQ-035 A response pending when reset is asserted SHALL be discarded; no pX_rsp SHALL be produced in the cycle after reset.

Verification
REQ-036 Single read: p0 reads 0x1000 with t_rdata = 0x0000_0042 -> p0_gnt at cycle N; p0_rsp with p0_rdata = 0x42 and p0_error = 0 at N+1.
REQ-037 Contention: p0 and p1 request together repeatedly from reset with PRIO_RESET = 0 -> grant order p0, p1, p0, p1, one grant per cycle; each rsp goes to the correct port 1 cycle later.
REQ-038 Lock: p1 reads 0x1004 with lock = 1, then 0x1000 with lock = 0, while p0 requests continuously -> p1, p1 granted consecutively; p0 granted only on the 3rd cycle.
REQ-039 Error: p1 writes 0x1010 with t_error = 1 -> p1_rsp = 1 and p1_error = 1 at N+1; p0 outputs stay 0.
REQ-040 Reset mid-operation: assert g_reset in the cycle after p0_gnt -> no p0_rsp; lock is cleared; prio = PRIO_RESET; the next request is serviced normally.
